exu_muldiv: RTL

EXU_MULDIV -- requirements
Module: exu_muldiv

---
 rtl/exu_muldiv_pkg.sv | 28 ++
 rtl/exu_muldiv_if.sv | 27 ++
 rtl/muldiv_iter.sv | 60 ++++++
 rtl/exu_muldiv.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/exu_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings and FSM states.
package exu_muldiv_pkg;

    localparam int MDU_OP_WIDTH = 3;

    // RV32M funct3 encodings
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

    // Control FSM states, exported for observation through the debug port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic op_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/exu_muldiv_if.sv
// Pipeline-side signals of the multiply/divide unit.
// Handshake: start_i is a level request held by the pipeline while stallreq_o=1;
// the unit presents result_o for exactly one cycle with ready_o=1, during which
// stallreq_o drops so the instruction retires with the result.
interface exu_muldiv_if;
    import exu_muldiv_pkg::*;

    logic                    start_i;
    logic [MDU_OP_WIDTH-1:0] op_i;
    logic [31:0]             src1_i;
    logic [31:0]             src2_i;
    logic                    flush_i;
    logic [31:0]             result_o;
    logic                    ready_o;
    logic                    stallreq_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, flush_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, flush_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-division step per cycle.
// acc holds {high, low} for multiply and {remainder, quotient} for divide.
module muldiv_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc_next,
    output logic        last
);

    logic [63:0] acc;
    logic [31:0] operand_b;
    logic [5:0]  cnt;
    logic        div_mode;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [31:0] rem_diff;
    logic        rem_ge;
    logic [63:0] div_next;

    // Next accumulator value for one iteration of either algorithm
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand_b} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        // Partial remainder is 33 bits wide after the shift; when it is >= the
        // divisor the difference is below 2^32, so a 32-bit subtract is exact.
        rem_sh   = acc[63:31];
        rem_ge   = (rem_sh >= {1'b0, operand_b});
        rem_diff = rem_sh[31:0] - operand_b;
        div_next = {(rem_ge ? rem_diff : rem_sh[31:0]), acc[30:0], rem_ge};
        acc_next = div_mode ? div_next : mul_next;
    end

    assign last = (cnt == 6'd31);

    // Operand capture and per-cycle iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 64'd0;
            operand_b <= 32'd0;
            cnt       <= 6'd0;
            div_mode  <= 1'b0;
        end else if (load) begin
            acc       <= {32'd0, a_mag};
            operand_b <= b_mag;
            cnt       <= 6'd0;
            div_mode  <= is_div;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + 6'd1;
        end
    end

endmodule

// File: rtl/exu_muldiv.sv
// RV32M multiply/divide unit: sign handling, special cases and the control FSM
// around the muldiv_iter datapath.
module exu_muldiv
    import exu_muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    exu_muldiv_if.slave   bus,
    output state_t        dbg_state
);

    state_t state, state_nx;

    logic                    load;
    logic                    step;
    logic                    last;
    logic [63:0]             acc_next;

    logic [MDU_OP_WIDTH-1:0] op_q;
    logic                    neg_a_q;
    logic                    neg_b_q;
    logic                    ready_q;
    logic [31:0]             result_q;

    logic                    a_signed;
    logic                    b_signed;
    logic                    neg_a;
    logic                    neg_b;
    logic [31:0]             a_mag;
    logic [31:0]             b_mag;
    logic                    div_zero;
    logic                    div_ovf;
    logic [31:0]             special_res;
    logic [63:0]             prod;
    logic [31:0]             quot;
    logic [31:0]             rem;
    logic [31:0]             calc_res;
    logic [31:0]             res_nx;

    // Operand decode: sign flags, magnitudes and the results that skip iteration
    always_comb begin
        a_signed = (bus.op_i == MDU_MUL) || (bus.op_i == MDU_MULH) || (bus.op_i == MDU_MULHSU) ||
                   (bus.op_i == MDU_DIV) || (bus.op_i == MDU_REM);
        b_signed = (bus.op_i == MDU_MUL) || (bus.op_i == MDU_MULH) ||
                   (bus.op_i == MDU_DIV) || (bus.op_i == MDU_REM);
        neg_a    = a_signed && bus.src1_i[31];
        neg_b    = b_signed && bus.src2_i[31];
        a_mag    = neg_a ? (~bus.src1_i + 32'd1) : bus.src1_i;
        b_mag    = neg_b ? (~bus.src2_i + 32'd1) : bus.src2_i;
        div_zero = op_is_div(bus.op_i) && (bus.src2_i == 32'd0);
        div_ovf  = ((bus.op_i == MDU_DIV) || (bus.op_i == MDU_REM)) &&
                   (bus.src1_i == 32'h8000_0000) && (bus.src2_i == 32'hFFFF_FFFF);
        special_res = 32'd0;
        if (div_zero) begin
            special_res = bus.op_i[1] ? bus.src1_i : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_res = bus.op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Sign correction applied to the final iteration's value as CALC exits
    always_comb begin
        prod     = (neg_a_q ^ neg_b_q) ? (~acc_next + 64'd1) : acc_next;
        quot     = (neg_a_q ^ neg_b_q) ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
        rem      = neg_a_q ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
        calc_res = 32'd0;
        case (op_q)
            MDU_MUL:                        calc_res = prod[31:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_res = prod[63:32];
            MDU_DIV, MDU_DIVU:              calc_res = quot;
            default:                        calc_res = rem;
        endcase
        res_nx = (state == IDLE) ? special_res : calc_res;
    end

    // Next-state and datapath control; flush overrides everything
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        if (bus.flush_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        load     = 1'b1;
                        state_nx = (div_zero || div_ovf) ? DONE : CALC;
                    end
                end
                CALC: begin
                    step = 1'b1;
                    if (last) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Captured op and sign flags, registered result and ready pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MDU_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            if (load) begin
                op_q    <= bus.op_i;
                neg_a_q <= neg_a;
                neg_b_q <= neg_b;
            end
            ready_q <= (state_nx == DONE);
            if (state_nx == DONE) begin
                result_q <= res_nx;
            end
        end
    end

    muldiv_iter u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .is_div   (op_is_div(bus.op_i)),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_next (acc_next),
        .last     (last)
    );

    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.stallreq_o = rst_n && bus.start_i && (state != DONE) && !bus.flush_i;
    assign dbg_state      = state;

endmodule
